// File: rtl/logic_unit_arbiter.sv
// ============================================================================
//  Module   : logic_unit_arbiter
//  Purpose  : Round-robin sharing of one registered AND/OR/XOR/NOR unit
//             between N_REQ requesters; results come back tagged by id.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    input  logic [N_REQ*2-1:0]     op_sel,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [CNT_W-1:0]       op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [1:0] C_OP_AND = 2'b00;
    localparam logic [1:0] C_OP_OR  = 2'b01;
    localparam logic [1:0] C_OP_XOR = 2'b10;

    state_t             r_state;
    state_t             w_state_next;

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_sel;

    logic [N_REQ-1:0]   r_gnt;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [CNT_W-1:0]   r_count;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic               w_arb;
    logic               w_exec;
    logic [N_REQ-1:0]   w_gnt_onehot;

    logic [WIDTH-1:0]   w_op_a   [N_REQ];
    logic [WIDTH-1:0]   w_op_b   [N_REQ];
    logic [1:0]         w_op_sel [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_op_a[gi]   = op_a[gi*WIDTH +: WIDTH];
        assign w_op_b[gi]   = op_b[gi*WIDTH +: WIDTH];
        assign w_op_sel[gi] = op_sel[gi*2 +: 2];
    end

    function automatic logic [WIDTH-1:0] f_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       sel
    );
        logic [WIDTH-1:0] res;
        case (sel)
            C_OP_AND: res = a & b;
            C_OP_OR:  res = a | b;
            C_OP_XOR: res = a ^ b;
            default:  res = ~(a | b);
        endcase
        return res;
    endfunction

    // Search starts one past the last winner so a repeat requester goes last.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IDW'(idx);
            if (!w_found && req[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    assign w_gnt_onehot = N_REQ'(1) << w_winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_arb        = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_found) begin
                    w_arb        = 1'b1;
                    w_state_next = S_EXEC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_EXEC: begin
                w_exec       = 1'b1;
                w_state_next = S_RESP;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= IDW'(N_REQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_count     <= '0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            if (w_arb) begin
                r_gnt <= w_gnt_onehot;
                r_a   <= w_op_a[w_winner];
                r_b   <= w_op_b[w_winner];
                r_sel <= w_op_sel[w_winner];
                r_id  <= w_winner;
                r_ptr <= w_winner;
            end
            if (w_exec) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_data  <= f_eval(r_a, r_b, r_sel);
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign op_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// ============================================================================
//  Module   : tb_logic_unit_arbiter
//  Purpose  : Directed bench for logic_unit_arbiter with a transaction-level
//             reference model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int IDW     = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ*2-1:0]     op_sel;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic [CNT_W-1:0]       op_count;

    logic_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [WIDTH-1:0] lu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Model: each granted op occupies two edges; arbitration is allowed once
    // the previous op's window has closed.
    int               cyc = 0;
    bit               started = 0;
    int               m_ptr, m_free_at, m_busy_end, m_pend_at, m_pend_id, m_count;
    logic [WIDTH-1:0] m_pend_data;
    logic [N_REQ-1:0] m_gnt;
    logic             m_valid, m_busy;
    int               m_id;
    logic [WIDTH-1:0] m_data;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_gnt = '0; m_valid = 0; m_id = 0; m_data = '0; m_count = 0;
            m_ptr = N_REQ - 1; m_free_at = cyc + 1; m_busy_end = 0; m_pend_at = -1;
        end else begin
            m_gnt   = '0;
            m_valid = 0;
            if (m_pend_at == cyc) begin
                m_valid = 1; m_id = m_pend_id; m_data = m_pend_data;
                if (m_count < CNT_MAX) m_count++;
            end
            if (cyc >= m_free_at && req != '0) begin
                int  w;
                bit  found;
                w = 0; found = 0;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (!found && req[(m_ptr + k) % N_REQ]) begin
                        found = 1; w = (m_ptr + k) % N_REQ;
                    end
                end
                m_gnt       = N_REQ'(1) << w;
                m_pend_id   = w;
                m_pend_data = lu(op_a[w*WIDTH +: WIDTH], op_b[w*WIDTH +: WIDTH], op_sel[w*2 +: 2]);
                m_pend_at   = cyc + 1;
                m_free_at   = cyc + 2;
                m_busy_end  = cyc + 2;
                m_ptr       = w;
            end
        end
        m_busy  = (cyc < m_busy_end);
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc gnt", 32'(gnt), 32'(m_gnt));
            check("cyc gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("cyc busy", 32'(busy), 32'(m_busy));
            check("cyc rsp_valid", 32'(rsp_valid), 32'(m_valid));
            check("cyc rsp_id", 32'(rsp_id), 32'(m_id));
            check("cyc rsp_data", 32'(rsp_data), 32'(m_data));
            check("cyc op_count", 32'(op_count), 32'(m_count));
        end
    end

    int gnt_log[$];
    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) if (gnt[i]) gnt_log.push_back(i);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [1:0]       t_sel [4];
        logic [WIDTH-1:0] t_exp [4];
        int               rr_exp [8];
        int               ws_exp [3];
        t_sel  = '{2'd1, 2'd0, 2'd2, 2'd3};
        t_exp  = '{8'h0E, 8'h08, 8'h06, 8'hF1};
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        ws_exp = '{1, 3, 1};

        rst = 1; req = '0; op_a = '0; op_b = '0; op_sel = '0;
        tick(2);
        rst = 0;
        tick(5);
        check("idle gnt", 32'(gnt), 32'h0);
        check("idle busy", 32'(busy), 32'h0);
        check("idle count", 32'(op_count), 32'h0);

        // Single ops from requester 2
        for (int i = 0; i < 4; i++) begin
            op_a[2*WIDTH +: WIDTH] = 8'h0C;
            op_b[2*WIDTH +: WIDTH] = 8'h0A;
            op_sel[2*2 +: 2]       = t_sel[i];
            req = 4'b0100;
            tick(1);
            check("single gnt", 32'(gnt), 32'h4);
            req = '0;
            tick(1);
            check("single rsp_valid", 32'(rsp_valid), 32'h1);
            check("single rsp_id", 32'(rsp_id), 32'h2);
            check("single rsp_data", 32'(rsp_data), 32'(t_exp[i]));
            tick(1);
        end
        check("single count", 32'(op_count), 32'h4);

        // Round-robin fairness
        rst = 1; tick(1); rst = 0;
        gnt_log.delete();
        req = 4'b1111;
        tick(16);
        check("rr count", 32'(op_count), 32'h8);
        req = '0;
        check("rr grants", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < gnt_log.size()) check("rr order", 32'(gnt_log[i]), 32'(rr_exp[i]));
        tick(1);

        // Wrap and skip from pointer 3
        gnt_log.delete();
        req = 4'b1010;
        tick(5);
        req = '0;
        tick(1);
        check("wrap grants", 32'(gnt_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < gnt_log.size()) check("wrap order", 32'(gnt_log[i]), 32'(ws_exp[i]));
        tick(2);

        // Reset while a grant is outstanding
        rst = 1; tick(1); rst = 0;
        op_a = '0; op_b = '0; op_sel = '0;
        req = 4'b0001;
        tick(1);
        check("midrst gnt", 32'(gnt), 32'h1);
        rst = 1; req = '0;
        tick(1);
        check("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst count", 32'(op_count), 32'h0);
        rst = 0;
        tick(3);
        check("midrst quiet", 32'(rsp_valid), 32'h0);
        req = 4'b0001;
        tick(1);
        check("midrst regnt", 32'(gnt), 32'h1);
        req = '0;
        tick(1);
        check("midrst rsp_id", 32'(rsp_id), 32'h0);
        check("midrst count1", 32'(op_count), 32'h1);
        tick(1);

        // Operand change after grant must not leak into the result
        op_a[0 +: WIDTH] = 8'hFF;
        op_b[0 +: WIDTH] = 8'h00;
        op_sel[0 +: 2]   = 2'd2;
        req = 4'b0001;
        tick(1);
        check("late gnt", 32'(gnt), 32'h1);
        op_a[0 +: WIDTH] = 8'h00;
        req = '0;
        tick(1);
        check("late rsp_data", 32'(rsp_data), 32'hFF);
        tick(1);

        // Counter saturation with changing operands
        rst = 1; tick(1); rst = 0;
        req = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            op_a   = $urandom;
            op_b   = $urandom;
            op_sel = 8'($urandom);
            tick(1);
        end
        check("sat count", 32'(op_count), 32'(CNT_MAX));
        req = '0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
